// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle controller.
// Holds the ALU opcode set, the FSM state encoding, the instruction type
// field codes and the ALU B-operand select codes, so the decoder and the
// controller agree on every encoding.
package multicycle_controller_pkg;

    // ALU opcodes, taken directly from the opc field of the instruction
    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_RSB = 3'b010,
        OP_AND = 3'b011,
        OP_ORR = 3'b100,
        OP_TST = 3'b101,
        OP_CMP = 3'b110,
        OP_MOV = 3'b111
    } alu_op_e;

    // Controller states; codes 9..15 are unreachable
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_DP_EXEC  = 4'd2,
        ST_DP_WB    = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WB   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_BRANCH   = 4'd8
    } state_e;

    // Instruction class, ir[29:28]
    typedef enum logic [1:0] {
        TYPE_DP      = 2'b00,
        TYPE_MEM     = 2'b01,
        TYPE_BRANCH  = 2'b10,
        TYPE_ILLEGAL = 2'b11
    } instr_type_e;

    // ALU B-operand selects
    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_SE12 = 2'b10;
    localparam logic [1:0] SRCB_SE26 = 2'b11;

endpackage

// File: rtl/multicycle_controller_instr_decoder.sv
// Combinational instruction field decoder.
// Ports:
//   ir         in  32  instruction register contents
//   instr_type out  2  instruction class (ir[29:28])
//   imm        out  1  immediate operand flag (ir[23])
//   set_flags  out  1  S bit (ir[19])
//   load       out  1  L bit for transfers (ir[20])
//   opc        out  3  data-processing opcode (ir[22:20])
//   is_test    out  1  opcode only updates flags (TST/CMP)
//   is_arith   out  1  opcode produces carry/overflow (ADD/SUB/RSB/CMP)
module multicycle_controller_instr_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [31:0] ir,
    output instr_type_e instr_type,
    output logic        imm,
    output logic        set_flags,
    output logic        load,
    output alu_op_e     opc,
    output logic        is_test,
    output logic        is_arith
);

    // Condition and operand fields are consumed elsewhere
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir[31:30], ir[27:24], ir[18:0]};

    assign instr_type = instr_type_e'(ir[29:28]);
    assign imm        = ir[23];
    assign opc        = alu_op_e'(ir[22:20]);
    assign load       = ir[20];
    assign set_flags  = ir[19];

    // TST and CMP only write flags, so they skip the writeback cycle
    assign is_test  = (opc == OP_TST) || (opc == OP_CMP);
    assign is_arith = (opc == OP_ADD) || (opc == OP_SUB) ||
                      (opc == OP_RSB) || (opc == OP_CMP);

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle processor control FSM.
// Sequences fetch, decode and the per-class execute steps, driving datapath
// mux selects, write enables and ALU opcode from the current state and ir.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ir[31:0], cond_ok   instruction and condition-check result
//   pc_write .. illegal single-bit datapath controls / status
//   alu_src_b[1:0]      ALU B select, alu_op[2:0] ALU opcode
//   check[1:0]          condition code forwarded to the flag unit
//   state[3:0]          current state for debug
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        cond_ok,
    output logic        pc_write,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic        flag_write,
    output logic        flag_select,
    output logic        pc_src,
    output logic        instr_done,
    output logic        illegal,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic [1:0]  check,
    output logic [3:0]  state
);

    instr_type_e instr_type;
    logic        imm;
    logic        set_flags;
    logic        load;
    alu_op_e     opc;
    logic        is_test;
    logic        is_arith;

    state_e      state_q;
    state_e      state_d;
    alu_op_e     alu_op_sel;

    multicycle_controller_instr_decoder u_decoder (
        .ir         (ir),
        .instr_type (instr_type),
        .imm        (imm),
        .set_flags  (set_flags),
        .load       (load),
        .opc        (opc),
        .is_test    (is_test),
        .is_arith   (is_arith)
    );

    // State register; reset drops straight back to FETCH so an interrupted
    // instruction never reaches its write step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control outputs; everything defaults to inactive,
    // ALU to ADD and B-select to the register operand
    always_comb begin
        state_d     = state_q;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        alu_src_a   = 1'b0;
        flag_write  = 1'b0;
        flag_select = 1'b0;
        pc_src      = 1'b0;
        instr_done  = 1'b0;
        illegal     = 1'b0;
        alu_src_b   = SRCB_REG;
        alu_op_sel  = OP_ADD;
        check       = ir[31:30];

        case (state_q)
            ST_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
                pc_write  = 1'b1;
                state_d   = ST_DECODE;
            end
            ST_DECODE: begin
                // Branch target is precomputed here whatever the class
                alu_src_b = SRCB_SE26;
                if (!cond_ok) begin
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end else begin
                    case (instr_type)
                        TYPE_DP:     state_d = ST_DP_EXEC;
                        TYPE_MEM:    state_d = ST_MEM_ADDR;
                        TYPE_BRANCH: state_d = ST_BRANCH;
                        default: begin
                            illegal    = 1'b1;
                            instr_done = 1'b1;
                            state_d    = ST_FETCH;
                        end
                    endcase
                end
            end
            ST_DP_EXEC: begin
                alu_src_a   = 1'b1;
                alu_src_b   = imm ? SRCB_SE12 : SRCB_REG;
                alu_op_sel  = opc;
                flag_write  = set_flags || is_test;
                flag_select = is_arith;
                if (is_test) begin
                    instr_done = 1'b1;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_DP_WB;
                end
            end
            ST_DP_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SE12;
                state_d   = load ? ST_MEM_RD : ST_MEM_WR;
            end
            ST_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                state_d  = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WR: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_BRANCH: begin
                pc_write   = 1'b1;
                pc_src     = 1'b1;
                instr_done = 1'b1;
                state_d    = ST_FETCH;
            end
            default: begin
                // Corrupted state code: recover quietly with nothing driven
                check   = 2'b00;
                state_d = ST_FETCH;
            end
        endcase
    end

    assign alu_op = alu_op_sel;
    assign state  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard testbench for multicycle_controller.
// Each issued instruction expands into its expected per-cycle control trace
// from a reference model; a monitor pops one record per cycle and compares.
module tb_multicycle_controller;

    // Opcode values of interest, written independently of the design package
    localparam logic [2:0] K_ADD = 3'd0;
    localparam logic [2:0] K_SUB = 3'd1;
    localparam logic [2:0] K_RSB = 3'd2;
    localparam logic [2:0] K_TST = 3'd5;
    localparam logic [2:0] K_CMP = 3'd6;
    localparam logic [2:0] K_MOV = 3'd7;

    typedef struct packed {
        logic [3:0] st;
        logic pcw, irw, iord, mrd, mwr, rgw, m2r, srca, fw, fs, psrc, done, ill;
        logic [1:0] srcb;
        logic [2:0] op;
        logic [1:0] chk;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] ir;
    logic        cond_ok;
    logic pc_write, ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg;
    logic alu_src_a, flag_write, flag_select, pc_src, instr_done, illegal;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] check;
    logic [3:0] state;

    exp_t gotVec;
    exp_t expQ[$];
    int   nChecks = 0;
    int   nFails  = 0;

    multicycle_controller dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ir          (ir),
        .cond_ok     (cond_ok),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .i_or_d      (i_or_d),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .flag_write  (flag_write),
        .flag_select (flag_select),
        .pc_src      (pc_src),
        .instr_done  (instr_done),
        .illegal     (illegal),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .check       (check),
        .state       (state)
    );

    assign gotVec = {state, pc_write, ir_write, i_or_d, mem_read, mem_write,
                     reg_write, mem_to_reg, alu_src_a, flag_write, flag_select,
                     pc_src, instr_done, illegal, alu_src_b, alu_op, check};

    // Free-running clock, period 10
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check, reports any miss
    task automatic checkOutput(input string name, input logic [23:0] got, input logic [23:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got=%h required=%h", name, got, exp);
        end
    endtask

    // An idle record for the given instruction: nothing asserted
    function automatic exp_t blank(input logic [31:0] i, input logic [3:0] st);
        exp_t e;
        e     = '0;
        e.st  = st;
        e.chk = i[31:30];
        return e;
    endfunction

    function automatic exp_t fetchRec(input logic [31:0] i);
        exp_t e;
        e      = blank(i, 4'd0);
        e.mrd  = 1'b1;
        e.irw  = 1'b1;
        e.srcb = 2'b01;
        e.pcw  = 1'b1;
        return e;
    endfunction

    // Reference model: spells out the whole cycle-by-cycle trace of one
    // instruction from the ISA rules and queues it; returns its length
    task automatic pushInstr(input logic [31:0] i, input logic c, output int n);
        exp_t e;
        logic [1:0] typ;
        logic [2:0] opc;
        bit   testOp;
        typ = i[29:28];
        opc = i[22:20];
        testOp = (opc == K_TST) || (opc == K_CMP);
        n = 0;
        expQ.push_back(fetchRec(i)); n++;
        e = blank(i, 4'd1);
        e.srcb = 2'b11;
        if (!c || typ == 2'b11) begin
            e.done = 1'b1;
            e.ill  = c;
            expQ.push_back(e); n++;
            return;
        end
        expQ.push_back(e); n++;
        if (typ == 2'b00) begin
            e = blank(i, 4'd2);
            e.srca = 1'b1;
            e.srcb = i[23] ? 2'b10 : 2'b00;
            e.op   = opc;
            e.fw   = i[19] || testOp;
            e.fs   = (opc == K_ADD) || (opc == K_SUB) || (opc == K_RSB) || (opc == K_CMP);
            e.done = testOp;
            expQ.push_back(e); n++;
            if (!testOp) begin
                e = blank(i, 4'd3);
                e.rgw = 1'b1; e.done = 1'b1;
                expQ.push_back(e); n++;
            end
        end else if (typ == 2'b01) begin
            e = blank(i, 4'd4);
            e.srca = 1'b1; e.srcb = 2'b10;
            expQ.push_back(e); n++;
            if (i[20]) begin
                e = blank(i, 4'd5);
                e.mrd = 1'b1; e.iord = 1'b1;
                expQ.push_back(e); n++;
                e = blank(i, 4'd6);
                e.rgw = 1'b1; e.m2r = 1'b1; e.done = 1'b1;
                expQ.push_back(e); n++;
            end else begin
                e = blank(i, 4'd7);
                e.mwr = 1'b1; e.iord = 1'b1; e.done = 1'b1;
                expQ.push_back(e); n++;
            end
        end else begin
            e = blank(i, 4'd8);
            e.pcw = 1'b1; e.psrc = 1'b1; e.done = 1'b1;
            expQ.push_back(e); n++;
        end
    endtask

    // Build an instruction word with the interesting fields set, rest random
    function automatic logic [31:0] mkIr(input logic [1:0] cc, input logic [1:0] typ,
                                         input logic imm, input logic [2:0] opc, input logic s);
        logic [31:0] w;
        w = $urandom();
        w[31:30] = cc;
        w[29:28] = typ;
        w[23]    = imm;
        w[22:20] = opc;
        w[19]    = s;
        return w;
    endfunction

    // Called just after a rising edge with the DUT in FETCH; leaves at the
    // same point of the following FETCH
    task automatic applyStimulus(input logic [31:0] i, input logic c);
        int n;
        ir      = i;
        cond_ok = c;
        pushInstr(i, c, n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one expected record per active cycle
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput($sformatf("trace_st%0d", e.st), gotVec, e);
        end
    end

    initial begin
        rst_n   = 1'b0;
        ir      = 32'h0;
        cond_ok = 1'b0;
        #1;
        checkOutput("reset_fetch", gotVec, fetchRec(32'h0));
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed cases covering every path and latency
        applyStimulus(mkIr(2'b11, 2'b00, 1'b1, K_ADD, 1'b1), 1'b1);
        applyStimulus(mkIr(2'b11, 2'b00, 1'b0, K_CMP, 1'b0), 1'b1);
        applyStimulus(mkIr(2'b01, 2'b00, 1'b1, K_TST, 1'b0), 1'b1);
        applyStimulus(mkIr(2'b10, 2'b00, 1'b0, K_MOV, 1'b0), 1'b1);
        applyStimulus(mkIr(2'b10, 2'b00, 1'b0, K_SUB, 1'b0), 1'b1);
        applyStimulus(mkIr(2'b11, 2'b01, 1'b1, 3'b001, 1'b0), 1'b1);
        applyStimulus(mkIr(2'b11, 2'b01, 1'b1, 3'b110, 1'b1), 1'b1);
        applyStimulus(mkIr(2'b11, 2'b10, 1'b0, 3'b000, 1'b0), 1'b1);
        applyStimulus(mkIr(2'b00, 2'b10, 1'b0, 3'b000, 1'b0), 1'b0);
        applyStimulus(mkIr(2'b11, 2'b11, 1'b0, 3'b000, 1'b0), 1'b1);
        applyStimulus(mkIr(2'b01, 2'b11, 1'b0, 3'b000, 1'b0), 1'b0);

        // Asynchronous reset in the middle of a store's write cycle
        ir      = mkIr(2'b11, 2'b01, 1'b0, 3'b000, 1'b0);
        cond_ok = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("store_in_memwr", {20'h0, state}, 24'd7);
        checkOutput("store_memwrite", {23'h0, mem_write}, 24'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_state", {20'h0, state}, 24'd0);
        checkOutput("async_rst_memwrite", {23'h0, mem_write}, 24'd0);
        checkOutput("async_rst_fetch", gotVec, fetchRec(ir));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random instruction stream, condition mostly passing
        for (int k = 0; k < 80; k++) begin
            applyStimulus($urandom(), ($urandom_range(3) != 0));
        end

        repeat (2) @(posedge clk);
        checkOutput("queue_drained", {8'h0, 16'(expQ.size())}, 24'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 SHALL have port: ir  in  32  instruction-register contents, stable from DECODE onward.
REQ-003 SHALL have port: cond_ok  in  1  condition result from flag unit for check=ir[31:30].
REQ-004 SHALL have outputs, all 1 bit: pc_write, ir_write, i_or_d (0=PC address, 1=ALU-out address), mem_read, mem_write, reg_write, mem_to_reg, alu_src_a (0=PC, 1=ReadData1), flag_write, flag_select (C/V update enable), pc_src (0=ALU result, 1=ALU-out register), instr_done, illegal.
REQ-005 SHALL have outputs: alu_src_b  out  2  (00=ReadData2, 01=constant 4, 10=SE12, 11=SE26); alu_op  out  3  ALU opcode; check  out  2  =ir[31:30]; state  out  4  current state, for debug.

Function
REQ-006 Decode: ir[29:28] type (00 data-proc, 01 transfer, 10 branch, 11 illegal); ir[23] I (immediate); ir[22:20] opc; ir[20] L for transfer (1=load); ir[19] S.
REQ-007 States, with codes 0 to 8: FETCH, DECODE, DP_EXEC, DP_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH.
REQ-008 FETCH: mem_read=1, i_or_d=0, ir_write=1, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_write=1, pc_src=0; next DECODE.
REQ-009 DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (pre-computes branch target).
REQ-010 DECODE next state: cond_ok=0 -> FETCH with instr_done=1. Otherwise type 00 -> DP_EXEC, 01 -> MEM_ADDR, 10 -> BRANCH. Type 11 -> FETCH with illegal=1 and instr_done=1.
REQ-011 DP_EXEC: alu_src_a=1, alu_src_b=10 if I else 00, alu_op=opc.
REQ-012 DP_EXEC flags: flag_write=1 when S=1 or opc in {TST, CMP}; flag_select=1 only when opc in {ADD, SUB, RSB, CMP}.
REQ-013 DP_EXEC next state: TST/CMP -> FETCH with instr_done=1; otherwise DP_WB.
REQ-014 DP_WB: reg_write=1, mem_to_reg=0, instr_done=1; next FETCH.
REQ-015 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD; next MEM_RD if L=1, else MEM_WR.
REQ-016 MEM_RD: mem_read=1, i_or_d=1; next MEM_WB.
REQ-017 MEM_WB: reg_write=1, mem_to_reg=1, instr_done=1; next FETCH.
REQ-018 MEM_WR: mem_write=1, i_or_d=1, instr_done=1; next FETCH.
REQ-019 BRANCH: pc_write=1, pc_src=1, instr_done=1; next FETCH.
REQ-020 All outputs SHALL be Moore/Mealy-combinational from state and ir/cond_ok. Any output not listed for a state SHALL be 0; alu_op defaults to ADD and alu_src_b defaults to 00.
REQ-021 Latency SHALL be: data-proc 4 cycles, TST/CMP 3, load 5, store 4, branch taken 3, condition failed 2, illegal 2.
REQ-022 mem_write and mem_read SHALL never be asserted in the same cycle. pc_write SHALL be asserted only in FETCH and BRANCH.
REQ-023 An unreachable state code SHALL return to FETCH on the next edge with all outputs 0.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state=FETCH; the FETCH outputs then appear combinationally.
REQ-025 Deassertion SHALL take effect at the next rising clk.
REQ-026 Reset mid-instruction SHALL abandon the instruction with no further reg_write or mem_write.

Structure
REQ-027 A shared package SHALL hold the opcode constants ADD..MOV (000..111), the state encoding, the type field codes and the alu_src_b select codes.
REQ-028 One sub-module is natural: instr_decoder, combinational, producing type, I, S, L, opc, is_test and is_arith from ir. The state register and output logic stay in this module.

Verification
REQ-029 ir=ADD, I=1, S=1, cond AL, cond_ok=1 -> states 0,1,2,3. In state 2: alu_src_b=10, flag_write=1, flag_select=1. In state 3: reg_write=1, instr_done=1.
REQ-030 ir=CMP, cond_ok=1 -> states 0,1,2,0. flag_write=1 in state 2; no reg_write throughout.
REQ-031 Load with L=1 -> states 0,1,4,5,6. mem_read=1 and i_or_d=1 in state 5; mem_to_reg=1 and reg_write=1 in state 6.
REQ-032 Branch EQ with cond_ok=0 -> states 0,1,0. instr_done=1 in state 1; pc_write never asserted in state 1.
REQ-033 rst_n pulled low during MEM_WR, asynchronously to clk -> state=0 immediately, mem_write=0 within the same cycle.
REQ-034 ir[29:28]=11 -> illegal=1 for one cycle in DECODE, then FETCH.
